// File: rtl/smem_writer_pkg.sv
// Shared constants and FSM encoding for the result writer.
// Line geometry matches the upstream queue RAM output lines.
package smem_writer_pkg;

    localparam int LINE_W = 512;
    localparam int LINE_BYTES = 64;
    localparam logic [31:0] TRAILER_MAGIC = 32'h534D454D;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REQ,
        STREAM,
        DRAIN,
        TRAILER,
        DONE
    } state_t;

endpackage

// File: rtl/smem_line_fifo.sv
// Synchronous line FIFO; push and pop together at full is accepted.
// Read data is the combinational head entry.
module smem_line_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 512
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/smem_result_writer.sv
// Absorbs upstream result lines into a FIFO and writes them to host
// memory in order, followed by a count/magic trailer line.
module smem_result_writer #(
    parameter int          FIFO_DEPTH    = 16,
    parameter int          ADDR_W        = 64,
    parameter logic [31:0] TRAILER_MAGIC = smem_writer_pkg::TRAILER_MAGIC
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic [ADDR_W-1:0]                  base_addr,
    input  logic                               output_request,
    output logic                               output_permit,
    input  logic [smem_writer_pkg::LINE_W-1:0] output_data,
    input  logic                               output_valid,
    input  logic                               output_finish,
    output logic                               out_stall,
    output logic                               wr_valid,
    output logic [ADDR_W-1:0]                  wr_addr,
    output logic [smem_writer_pkg::LINE_W-1:0] wr_data,
    input  logic                               wr_ready,
    output logic                               done,
    output logic                               overflow,
    output logic [31:0]                        line_count
);

    import smem_writer_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_AT = CW'(FIFO_DEPTH - 2);

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [31:0]         wr_idx;
    logic [31:0]         load_idx;
    logic [ADDR_W-1:0]   load_addr;
    logic [ADDR_W-1:0]   trailer_addr;
    logic [LINE_W-1:0]   trailer_line;
    logic [LINE_W-1:0]   fifo_dout;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       next_count;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_push;
    logic                fifo_pop;
    logic                in_stream;
    logic                push_req;
    logic                hs;
    logic                drain_done;

    assign in_stream = (state == STREAM) || (state == DRAIN);
    assign push_req  = output_valid && in_stream;
    assign hs        = wr_valid && wr_ready;
    assign fifo_pop  = (!wr_valid || wr_ready) && !fifo_empty;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign next_count = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    // A line loaded in the same cycle as a handshake takes the next slot.
    assign load_idx  = wr_idx + 32'(hs);
    assign load_addr = base_q
                     + ADDR_W'(load_idx) * ADDR_W'(LINE_BYTES);
    assign trailer_addr = base_q
                        + ADDR_W'(line_count) * ADDR_W'(LINE_BYTES);
    assign trailer_line = {{(LINE_W - 64){1'b0}}, TRAILER_MAGIC, line_count};

    assign drain_done = (state == DRAIN) && fifo_empty
                     && !wr_valid && !push_req;

    smem_line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LINE_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (output_data),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            base_q        <= '0;
            wr_idx        <= '0;
            output_permit <= 1'b0;
            out_stall     <= 1'b0;
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            line_count    <= '0;
        end else begin
            if (push_req) begin
                line_count <= line_count + 32'd1;
            end
            if (push_req && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            if (hs) begin
                wr_idx <= wr_idx + 32'd1;
            end
            out_stall <= in_stream && (next_count >= STALL_AT);

            if (fifo_pop) begin
                wr_valid <= 1'b1;
                wr_addr  <= load_addr;
                wr_data  <= fifo_dout;
            end else if (hs) begin
                wr_valid <= 1'b0;
            end

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= WAIT_REQ;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
                        line_count <= '0;
                        wr_idx     <= '0;
                        base_q     <= {base_addr[ADDR_W-1:6], 6'b0};
                    end
                end
                WAIT_REQ: begin
                    if (output_request) begin
                        state         <= STREAM;
                        output_permit <= 1'b1;
                    end
                end
                STREAM: begin
                    if (output_finish) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state         <= TRAILER;
                        output_permit <= 1'b0;
                        wr_valid      <= 1'b1;
                        wr_addr       <= trailer_addr;
                        wr_data       <= trailer_line;
                    end
                end
                TRAILER: begin
                    if (wr_ready) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smem_result_writer.sv
// Randomized directed bench for smem_result_writer with a queue-based
// model of the expected host write stream.
module tb_smem_result_writer;

    typedef struct packed {
        logic [63:0]  a;
        logic [511:0] d;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [63:0]  base_addr;
    logic         output_request;
    logic         output_permit;
    logic [511:0] output_data;
    logic         output_valid;
    logic         output_finish;
    logic         out_stall;
    logic         wr_valid;
    logic [63:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_ready;
    logic         done;
    logic         overflow;
    logic [31:0]  line_count;

    int checks = 0;
    int passed = 0;
    int fails = 0;

    exp_t q[$];
    logic [63:0] base_m;
    int model_count;
    int n_push;
    int hs_count = 0;
    int hs_base;
    int occ;
    int max_occ;
    int rdy_mode;
    bit stall_prev;
    bit stall_chk;
    bit stall_hi;
    bit mon_en;
    bit hold_prev;
    logic [63:0]  prev_addr;
    logic [511:0] prev_data;

    smem_result_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .output_request (output_request),
        .output_permit  (output_permit),
        .output_data    (output_data),
        .output_valid   (output_valid),
        .output_finish  (output_finish),
        .out_stall      (out_stall),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .done           (done),
        .overflow       (overflow),
        .line_count     (line_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] trailer_of(input int n);
        return {448'b0, 32'h534D454D, 32'(n)};
    endfunction

    // Host-side monitor: ordering, address, data and hold stability.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            occ = n_push - (hs_count - hs_base) - int'(wr_valid);
            if (occ > max_occ) max_occ = occ;
            if (out_stall) stall_hi = 1'b1;
            if (stall_chk)
                check("stall_rule", 512'(out_stall), 512'(occ >= 14));
            if (hold_prev) begin
                check("hold_valid", 512'(wr_valid), 512'(1));
                check("hold_addr", 512'(wr_addr), 512'(prev_addr));
                check("hold_data", wr_data, prev_data);
            end
            if (wr_valid && wr_ready) begin
                check("write_expected", 512'(q.size() > 0), 512'(1));
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("wr_addr", 512'(wr_addr), 512'(e.a));
                    check("wr_data", wr_data, e.d);
                end
                hs_count++;
            end
            hold_prev = wr_valid && !wr_ready;
            prev_addr = wr_addr;
            prev_data = wr_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic tick();
        stall_prev = out_stall;
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: wr_ready = 1'b0;
            1: wr_ready = 1'b1;
            2: wr_ready = ~wr_ready;
            default: wr_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic set_ready(input int mode);
        rdy_mode = mode;
        wr_ready = (mode == 1);
    endtask

    task automatic push_line(input logic [511:0] d, input bit drop);
        output_valid = 1'b1;
        output_data = d;
        tick();
        output_valid = 1'b0;
        model_count++;
        if (!drop) begin
            q.push_back({base_m + 64'(n_push) * 64'd64, d});
            n_push++;
        end
    endtask

    task automatic send_n(input int n, input bit honour);
        int sent = 0;
        for (int c = 0; c < n * 20 + 50 && sent < n; c++) begin
            if (!honour || !stall_prev) begin
                push_line(rand_line(), 1'b0);
                sent++;
            end else begin
                tick();
            end
        end
        check("send_complete", 512'(sent), 512'(n));
    endtask

    task automatic start_batch(input logic [63:0] b);
        base_m = {b[63:6], 6'b0};
        model_count = 0;
        n_push = 0;
        hs_base = hs_count;
        max_occ = 0;
        stall_hi = 1'b0;
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clears_count", 512'(line_count), 512'(0));
        output_request = 1'b1;
        for (int i = 0; i < 20 && !output_permit; i++) tick();
        check("permit_granted", 512'(output_permit), 512'(1));
    endtask

    task automatic finish_batch();
        output_finish = 1'b1;
        q.push_back({base_m + 64'(model_count) * 64'd64,
                     trailer_of(model_count)});
        for (int i = 0; i < 400 && !done; i++) tick();
        output_finish = 1'b0;
        output_request = 1'b0;
        check("done", 512'(done), 512'(1));
        check("line_count", 512'(line_count), 512'(model_count));
        check("permit_low", 512'(output_permit), 512'(0));
        check("queue_drained", 512'(q.size()), 512'(0));
        tick();
        check("done_level", 512'(done), 512'(1));
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        output_request = 1'b0;
        output_data = '0;
        output_valid = 1'b0;
        output_finish = 1'b0;
        mon_en = 1'b0;
        stall_chk = 1'b0;
        hold_prev = 1'b0;
        stall_prev = 1'b0;
        n_push = 0;
        hs_base = 0;
        max_occ = 0;
        set_ready(1);
        repeat (3) tick();
        check("rst_wr_valid", 512'(wr_valid), 512'(0));
        check("rst_wr_addr", 512'(wr_addr), 512'(0));
        check("rst_permit", 512'(output_permit), 512'(0));
        check("rst_stall", 512'(out_stall), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_overflow", 512'(overflow), 512'(0));
        check("rst_count", 512'(line_count), 512'(0));
        reset_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Header plus one mem line at 0x1000.
        start_batch(64'h1000);
        send_n(2, 1'b1);
        finish_batch();
        check("t1_overflow", 512'(overflow), 512'(0));

        // 30 lines against a stalled host; upstream reacts one cycle late.
        start_batch({$urandom, $urandom});
        set_ready(0);
        stall_chk = 1'b1;
        begin
            int sent = 0;
            for (int c = 0; c < 40; c++) begin
                if (sent < 30 && !stall_prev) begin
                    push_line(rand_line(), 1'b0);
                    sent++;
                end else begin
                    tick();
                end
            end
            check("t2_overflow_mid", 512'(overflow), 512'(0));
            set_ready(1);
            for (int c = 0; c < 400 && sent < 30; c++) begin
                if (!stall_prev) begin
                    push_line(rand_line(), 1'b0);
                    sent++;
                end else begin
                    tick();
                end
            end
            check("t2_sent", 512'(sent), 512'(30));
        end
        stall_chk = 1'b0;
        check("t2_stall_seen", 512'(stall_hi), 512'(1));
        check("t2_max_occ", 512'(max_occ <= 15), 512'(1));
        finish_batch();
        check("t2_overflow", 512'(overflow), 512'(0));

        // Host toggling ready every cycle.
        start_batch({$urandom, $urandom});
        set_ready(2);
        send_n(12, 1'b1);
        set_ready(2);
        finish_batch();

        // Fill completely, then push with the host accepting.
        start_batch({$urandom, $urandom});
        set_ready(0);
        send_n(17, 1'b0);
        check("t4a_full_no_ovf", 512'(overflow), 512'(0));
        set_ready(1);
        push_line(rand_line(), 1'b0);
        check("t4a_overflow", 512'(overflow), 512'(0));
        finish_batch();

        // Fill completely, then push with the host stalled.
        start_batch({$urandom, $urandom});
        set_ready(0);
        send_n(17, 1'b0);
        push_line(rand_line(), 1'b1);
        check("t4b_overflow", 512'(overflow), 512'(1));
        check("t4b_count", 512'(line_count), 512'(18));
        set_ready(1);
        push_line(rand_line(), 1'b0);
        check("t4b_sticky", 512'(overflow), 512'(1));
        finish_batch();
        check("t4b_sticky_end", 512'(overflow), 512'(1));

        // Finish while five lines are still queued.
        start_batch({$urandom, $urandom});
        set_ready(0);
        send_n(5, 1'b1);
        output_finish = 1'b1;
        repeat (10) tick();
        check("t5_not_done", 512'(done), 512'(0));
        check("t5_permit_drain", 512'(output_permit), 512'(1));
        check("t5_queue", 512'(q.size()), 512'(5));
        set_ready(1);
        finish_batch();

        // Start mid-stream is ignored; reset mid-stream abandons.
        start_batch({$urandom, $urandom});
        set_ready(3);
        send_n(3, 1'b1);
        base_addr = {$urandom, $urandom};
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_permit", 512'(output_permit), 512'(1));
        check("t6_count", 512'(line_count), 512'(3));
        send_n(2, 1'b1);
        check("t6_count2", 512'(line_count), 512'(5));
        set_ready(0);
        send_n(2, 1'b1);
        mon_en = 1'b0;
        reset_n = 1'b0;
        output_request = 1'b0;
        tick();
        check("t6_rst_valid", 512'(wr_valid), 512'(0));
        check("t6_rst_addr", 512'(wr_addr), 512'(0));
        check("t6_rst_data", wr_data, 512'(0));
        check("t6_rst_permit", 512'(output_permit), 512'(0));
        check("t6_rst_count", 512'(line_count), 512'(0));
        check("t6_rst_done", 512'(done), 512'(0));
        reset_n = 1'b1;
        q.delete();
        set_ready(3);
        tick();
        mon_en = 1'b1;
        start_batch({$urandom, $urandom});
        send_n(1, 1'b1);
        finish_batch();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
